// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I pipeline: load-use bubble insertion, branch flush,
// WB-to-ID capture bypass, MEM/WB operand forwarding and ALU operand selection.
module id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       id_opcode,
  input  logic [2:0]       id_func3,
  input  logic             id_func7,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [31:0]      id_rs1_data,
  input  logic [31:0]      id_rs2_data,
  input  logic [31:0]      id_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             flush,
  input  logic             hold,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [31:0]      mem_fwd_data,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic [31:0]      wb_data,
  output logic             stall_out,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [4:0]       ex_opcode,
  output logic [2:0]       ex_func3,
  output logic             ex_func7,
  output logic [4:0]       ex_rd,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_operand1,
  output logic [31:0]      ex_operand2,
  output logic [31:0]      ex_store_data,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpRType  = 5'b01100;
  localparam logic [4:0] OpBranch = 5'b11000;

  logic             valid_q, reg_write_q, mem_read_q, mem_write_q, func7_q;
  logic [4:0]       opcode_q, rd_q, rs1_idx_q, rs2_idx_q;
  logic [2:0]       func3_q;
  logic [31:0]      pc_q, rs1_val_q, rs2_val_q, imm_q;
  logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q;

  logic        load_use;
  logic [31:0] rs1_capture, rs2_capture, rs1_fwd, rs2_fwd;

  always_comb begin
    load_use = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid &
               ((id_uses_rs1 & (id_rs1 == rd_q)) | (id_uses_rs2 & (id_rs2 == rd_q)));
    stall_out = load_use & ~flush & ~hold;
  end

  // Register file writes in WB the same cycle ID reads it, so bypass the stale read.
  always_comb begin
    rs1_capture = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
    rs2_capture = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
  end

  function automatic logic [31:0] fwd_sel(input logic [4:0] idx, input logic [31:0] val);
    if (mem_reg_write && !mem_mem_read && mem_rd != 5'd0 && mem_rd == idx) begin
      return mem_fwd_data;
    end else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == idx) begin
      return wb_data;
    end
    return val;
  endfunction

  always_comb begin
    rs1_fwd = fwd_sel(rs1_idx_q, rs1_val_q);
    rs2_fwd = fwd_sel(rs2_idx_q, rs2_val_q);
    unique case (opcode_q)
      OpAuipc, OpJal, OpJalr: ex_operand1 = pc_q;
      OpLui:                  ex_operand1 = 32'd0;
      default:                ex_operand1 = rs1_fwd;
    endcase
    ex_operand2   = (opcode_q == OpRType || opcode_q == OpBranch) ? rs2_fwd : imm_q;
    ex_store_data = rs2_fwd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      func7_q      <= 1'b0;
      opcode_q     <= '0;
      rd_q         <= '0;
      rs1_idx_q    <= '0;
      rs2_idx_q    <= '0;
      func3_q      <= '0;
      pc_q         <= '0;
      rs1_val_q    <= '0;
      rs2_val_q    <= '0;
      imm_q        <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      opcode_q    <= '0;
      if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end else if (hold) begin
      // Freeze: every register keeps its value.
    end else if (load_use) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      opcode_q    <= '0;
      if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end else begin
      valid_q     <= id_valid;
      reg_write_q <= id_reg_write & id_valid;
      mem_read_q  <= id_mem_read & id_valid;
      mem_write_q <= id_mem_write & id_valid;
      func7_q     <= id_func7;
      opcode_q    <= id_opcode;
      rd_q        <= id_rd;
      rs1_idx_q   <= id_rs1;
      rs2_idx_q   <= id_rs2;
      func3_q     <= id_func3;
      pc_q        <= id_pc;
      rs1_val_q   <= rs1_capture;
      rs2_val_q   <= rs2_capture;
      imm_q       <= id_imm;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign ex_opcode    = opcode_q;
  assign ex_func3     = func3_q;
  assign ex_func7     = func7_q;
  assign ex_rd        = rd_q;
  assign ex_pc        = pc_q;
  assign bubble_cnt   = bubble_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule
